// File: rtl/bist_pattern_gen_if.sv
// Pattern-generator <-> checker bundle: start/result inputs,
// operand vector and run status outputs.
interface bist_pattern_gen_if;
    logic        start;
    logic        failed_flag;
    logic [7:0]  x1;
    logic [7:0]  x2;
    logic [7:0]  v;
    logic [7:0]  t;
    logic [7:0]  c;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] fail_count;
    logic [15:0] first_fail_idx;

    modport master (
        input  start, failed_flag,
        output x1, x2, v, t, c,
        output busy, done, pass, fail_count, first_fail_idx
    );

    modport slave (
        output start, failed_flag,
        input  x1, x2, v, t, c,
        input  busy, done, pass, fail_count, first_fail_idx
    );
endinterface

// File: rtl/bist_pattern_gen.sv
// LFSR-driven BIST vector generator: holds each 40-bit vector
// for HOLD_CYCLES, samples the checker verdict, reports results.
module bist_pattern_gen #(
    parameter int          NUM_VECTORS = 64,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [39:0] SEED        = 40'h00_0000_0001
) (
    input logic             clk,
    input logic             rst_n,
    bist_pattern_gen_if.master bus
);

    localparam logic [39:0] SEED_EFF  = (SEED == 40'h0) ? 40'h1 : SEED;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
    localparam logic [7:0]  LAST_HOLD = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] NONE      = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic        load;
    logic        check;
    logic        step;
    logic [39:0] lfsr;
    logic [39:0] lfsr_next;
    logic [39:0] pat;
    logic [15:0] vec_idx;
    logic [7:0]  hold_cnt;
    logic [15:0] fail_count;
    logic [15:0] first_fail_idx;

    assign lfsr_next = {lfsr[38:0],
                        lfsr[39] ^ lfsr[37] ^ lfsr[20] ^ lfsr[18]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and datapath control strobes
    always_comb begin
        state_next = state;
        load       = 1'b0;
        check      = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = HOLD;
                    load       = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == LAST_HOLD) begin
                    check = 1'b1;
                    if (vec_idx == LAST_IDX) state_next = DONE;
                    else                     step       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Vector sequencing and result accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr           <= SEED_EFF;
            pat            <= '0;
            vec_idx        <= '0;
            hold_cnt       <= '0;
            fail_count     <= '0;
            first_fail_idx <= NONE;
        end else if (load) begin
            lfsr           <= SEED_EFF;
            pat            <= SEED_EFF;
            vec_idx        <= '0;
            hold_cnt       <= '0;
            fail_count     <= '0;
            first_fail_idx <= NONE;
        end else if (state == HOLD) begin
            if (check) begin
                if (bus.failed_flag) begin
                    if (fail_count != NONE)
                        fail_count <= fail_count + 16'd1;
                    if (first_fail_idx == NONE)
                        first_fail_idx <= vec_idx;
                end
                if (step) begin
                    lfsr     <= lfsr_next;
                    pat      <= lfsr_next;
                    vec_idx  <= vec_idx + 16'd1;
                    hold_cnt <= '0;
                end
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    assign bus.x1             = pat[7:0];
    assign bus.x2             = pat[15:8];
    assign bus.v              = pat[23:16];
    assign bus.t              = pat[31:24];
    assign bus.c              = pat[39:32];
    assign bus.busy           = (state == HOLD);
    assign bus.done           = (state == DONE);
    assign bus.pass           = (state == DONE) && (fail_count == 16'h0);
    assign bus.fail_count     = fail_count;
    assign bus.first_fail_idx = first_fail_idx;

endmodule
